instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Turns a stream of fetched instruction words into decoded ops. An opcode
//   word whose source field selects register 7 takes an immediate: that op is
//   held until the next word arrives, then issued with it. Finished ops pass
//   through a small FIFO. The outputs always present the FIFO head entry.
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   flush               drops the partial op and the FIFO contents
//   in_word/in_valid/in_ready    fetched-word stream (in_ready = FIFO not full)
//   out_valid/out_ready          decoded-op handshake (out_valid = FIFO not empty)
//   dest_reg, src_reg, alu_op, alu_cond, imm, conditional, read_dest,
//   read_src, write_dest, has_immediate, mem_read, mem_write,
//   mem_post_increment, mem_pre_decrement, mem_base, mem_offset
//                        fields of the head op
module instr_decode_stage #(
  parameter int WORD_W    = 12,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        dest_reg,
  output logic [4:0]        src_reg,
  output logic [4:0]        alu_op,
  output logic [3:0]        alu_cond,
  output logic [WORD_W-1:0] imm,
  output logic              conditional,
  output logic              read_dest,
  output logic              read_src,
  output logic              write_dest,
  output logic              has_immediate,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_post_increment,
  output logic              mem_pre_decrement,
  output logic [1:0]        mem_base,
  output logic [3:0]        mem_offset
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]        dest;
    logic [4:0]        src;
    logic [4:0]        alu_op;
    logic [3:0]        alu_cond;
    logic [WORD_W-1:0] imm;
    logic              conditional;
    logic              read_dest;
    logic              read_src;
    logic              write_dest;
    logic              has_immediate;
    logic              mem_read;
    logic              mem_write;
    logic              mem_post_increment;
    logic              mem_pre_decrement;
    logic [1:0]        mem_base;
    logic [3:0]        mem_offset;
  } op_t;

  typedef enum logic {
    S_OPCODE,
    S_WAIT_IMM
  } state_t;

  state_t           state_q, state_d;
  op_t              latched_q;
  op_t              fifo_q [OUT_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;

  op_t              dec;
  op_t              pushOp;
  logic             pushEn, latchEn, accept, pop;

  logic [11:0]      ins;
  logic             isArith, isFlg, isShift, isLoad, isStore, special;

  assign ins     = in_word[11:0];
  assign isArith = (ins[10:9] != 2'b11);
  assign isFlg   = (ins[10:3] == 8'b1100_1101);
  // The flag op lives inside the shift encoding space and takes precedence.
  assign isShift = !isFlg && (ins[10:7] == 4'b1100);
  assign isLoad  = (ins[11:8] == 4'b0111);
  assign isStore = (ins[11:8] == 4'b1111);
  assign special = (ins[5:0] < 6'h0A);

  // Handshakes depend only on registered occupancy, so in_ready never sees out_ready.
  assign in_ready  = (count_q < CNT_W'(OUT_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && in_ready && !flush;

  // Field decode of the offered word; every field starts from its default.
  always_comb begin
    dec            = '0;
    dec.read_src   = 1'b1;
    dec.write_dest = 1'b1;
    if (isArith) begin
      dec.dest          = {1'b0, ins[10], ins[5:3]};
      dec.src           = {1'b0, ins[9], ins[2:0]};
      dec.alu_op        = {2'b00, ins[8:6]};
      dec.has_immediate = (ins[9] == 1'b0) && (ins[2:0] == 3'b111);
      dec.read_dest     = (ins[8:6] != 3'b000);
    end else if (isFlg) begin
      dec.dest   = 5'h1F;
      dec.src    = 5'h1F;
      dec.alu_op = 5'h00;
    end else if (isShift) begin
      dec.dest   = {1'b0, ins[3:0]};
      dec.src    = {1'b0, ins[3:0]};
      dec.alu_op = {2'b01, ins[6:4]};
    end else if (isLoad) begin
      dec.dest     = {3'b000, ins[7:6]};
      dec.src      = {1'b1, ins[3:0]};
      dec.read_src = special;
    end else if (isStore) begin
      dec.dest       = {1'b1, ins[3:0]};
      dec.src        = {3'b000, ins[7:6]};
      dec.write_dest = special;
    end else begin
      dec.dest       = {1'b0, ins[3:0]};
      dec.src        = {1'b0, ins[3:0]};
      dec.alu_op     = {1'b1, ins[11], ins[6], ins[5:4]};
      dec.alu_cond   = ins[3:0];
      dec.write_dest = 1'b0;
    end
    dec.conditional = ins[11] & (isArith | isShift);

    // Low six bits 0x0A..0x0F encode auto-modify addressing; anything else
    // above that range is a plain base plus offset.
    if ((isLoad || isStore) && !special) begin
      dec.mem_read  = isLoad;
      dec.mem_write = isStore;
      case (ins[5:0])
        6'h0A: begin dec.mem_base = 2'd1; dec.mem_post_increment = 1'b1; end
        6'h0B: begin dec.mem_base = 2'd1; dec.mem_pre_decrement  = 1'b1; end
        6'h0C: begin dec.mem_base = 2'd2; dec.mem_post_increment = 1'b1; end
        6'h0D: begin dec.mem_base = 2'd2; dec.mem_pre_decrement  = 1'b1; end
        6'h0E: begin dec.mem_base = 2'd3; dec.mem_post_increment = 1'b1; end
        6'h0F: begin dec.mem_base = 2'd3; dec.mem_pre_decrement  = 1'b1; end
        default: begin
          dec.mem_base   = ins[5:4];
          dec.mem_offset = ins[3:0];
        end
      endcase
    end
  end

  // Opcode/immediate sequencing: decides when an op is complete and pushed.
  always_comb begin
    state_d = state_q;
    pushEn  = 1'b0;
    latchEn = 1'b0;
    pushOp  = dec;
    case (state_q)
      S_OPCODE: begin
        if (accept) begin
          if (dec.has_immediate) begin
            latchEn = 1'b1;
            state_d = S_WAIT_IMM;
          end else begin
            pushEn = 1'b1;
          end
        end
      end
      S_WAIT_IMM: begin
        pushOp     = latched_q;
        pushOp.imm = in_word;
        if (accept) begin
          pushEn  = 1'b1;
          state_d = S_OPCODE;
        end
      end
      default: state_d = S_OPCODE;
    endcase
  end

  // State, latched op and FIFO storage. Reset also clears the storage so the
  // head fields read as zero afterwards; flush only empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_OPCODE;
      latched_q <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      for (int k = 0; k < OUT_DEPTH; k++) begin
        fifo_q[k] <= '0;
      end
    end else if (flush) begin
      state_q <= S_OPCODE;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (latchEn) begin
        latched_q <= dec;
      end
      if (pushEn) begin
        fifo_q[wrPtr_q] <= pushOp;
        wrPtr_q         <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(pushEn) - CNT_W'(pop);
    end
  end

  op_t head;
  assign head = fifo_q[rdPtr_q];

  assign dest_reg           = head.dest;
  assign src_reg            = head.src;
  assign alu_op             = head.alu_op;
  assign alu_cond           = head.alu_cond;
  assign imm                = head.imm;
  assign conditional        = head.conditional;
  assign read_dest          = head.read_dest;
  assign read_src           = head.read_src;
  assign write_dest         = head.write_dest;
  assign has_immediate      = head.has_immediate;
  assign mem_read           = head.mem_read;
  assign mem_write          = head.mem_write;
  assign mem_post_increment = head.mem_post_increment;
  assign mem_pre_decrement  = head.mem_pre_decrement;
  assign mem_base           = head.mem_base;
  assign mem_offset         = head.mem_offset;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage
//   Drives directed and random word streams into instr_decode_stage and
//   compares the head op and handshakes against a queue-based model each cycle.
module tb_instr_decode_stage;

  localparam int W     = 12;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]   dest;
    logic [4:0]   src;
    logic [4:0]   alu_op;
    logic [3:0]   alu_cond;
    logic [W-1:0] imm;
    logic         conditional;
    logic         read_dest;
    logic         read_src;
    logic         write_dest;
    logic         has_immediate;
    logic         mem_read;
    logic         mem_write;
    logic         mem_post_increment;
    logic         mem_pre_decrement;
    logic [1:0]   mem_base;
    logic [3:0]   mem_offset;
  } op_t;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_word;
  logic         in_ready, out_valid;
  logic [4:0]   dest_reg, src_reg, alu_op;
  logic [3:0]   alu_cond, mem_offset;
  logic [W-1:0] imm;
  logic         conditional, read_dest, read_src, write_dest, has_immediate;
  logic         mem_read, mem_write, mem_post_increment, mem_pre_decrement;
  logic [1:0]   mem_base;

  int errCount   = 0;
  int checkCount = 0;
  bit checkEn    = 1'b0;

  op_t modelQ[$];
  op_t pendOp;
  bit  pending = 1'b0;
  op_t dutOp;

  instr_decode_stage #(.WORD_W(W), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .dest_reg(dest_reg), .src_reg(src_reg), .alu_op(alu_op), .alu_cond(alu_cond),
    .imm(imm), .conditional(conditional), .read_dest(read_dest), .read_src(read_src),
    .write_dest(write_dest), .has_immediate(has_immediate), .mem_read(mem_read),
    .mem_write(mem_write), .mem_post_increment(mem_post_increment),
    .mem_pre_decrement(mem_pre_decrement), .mem_base(mem_base), .mem_offset(mem_offset)
  );

  always #5 clk = ~clk;

  assign dutOp = '{dest: dest_reg, src: src_reg, alu_op: alu_op, alu_cond: alu_cond,
                   imm: imm, conditional: conditional, read_dest: read_dest,
                   read_src: read_src, write_dest: write_dest,
                   has_immediate: has_immediate, mem_read: mem_read,
                   mem_write: mem_write, mem_post_increment: mem_post_increment,
                   mem_pre_decrement: mem_pre_decrement, mem_base: mem_base,
                   mem_offset: mem_offset};

  // Reference decode built from the instruction-set rules, field by field.
  function automatic op_t modelDecode(input logic [11:0] w);
    op_t o;
    int  v;
    bit  arith, flg, shift, load, store, special;
    o            = '0;
    o.read_src   = 1'b1;
    o.write_dest = 1'b1;
    v       = int'(w[5:0]);
    special = (v < 10);
    arith   = (w[10:9] != 2'b11);
    flg     = (w[10:3] == 8'hCD);
    shift   = !flg && (w[10:7] == 4'hC);
    load    = (w[11:8] == 4'h7);
    store   = (w[11:8] == 4'hF);
    if (arith) begin
      o.dest          = 5'(int'(w[10]) * 8 + int'(w[5:3]));
      o.src           = 5'(int'(w[9]) * 8 + int'(w[2:0]));
      o.alu_op        = 5'(int'(w[8:6]));
      o.has_immediate = (o.src == 5'd7);
      o.read_dest     = (o.alu_op != 5'd0);
    end else if (flg) begin
      o.dest = 5'd31;
      o.src  = 5'd31;
    end else if (shift) begin
      o.dest   = 5'(int'(w[3:0]));
      o.src    = o.dest;
      o.alu_op = 5'(8 + int'(w[6:4]));
    end else if (load) begin
      o.dest     = 5'(int'(w[7:6]));
      o.src      = 5'(16 + int'(w[3:0]));
      o.read_src = special;
    end else if (store) begin
      o.dest       = 5'(16 + int'(w[3:0]));
      o.src        = 5'(int'(w[7:6]));
      o.write_dest = special;
    end else begin
      o.dest       = 5'(int'(w[3:0]));
      o.src        = o.dest;
      o.alu_op     = 5'(16 + int'(w[11]) * 8 + int'(w[6]) * 4 + int'(w[5:4]));
      o.alu_cond   = w[3:0];
      o.write_dest = 1'b0;
    end
    o.conditional = w[11] && (arith || shift);
    if ((load || store) && !special) begin
      o.mem_read  = load;
      o.mem_write = store;
      if (v <= 15) begin
        o.mem_base           = 2'((v - 10) / 2 + 1);
        o.mem_post_increment = (v % 2 == 0);
        o.mem_pre_decrement  = (v % 2 == 1);
      end else begin
        o.mem_base   = 2'(v / 16);
        o.mem_offset = 4'(v % 16);
      end
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the clock edge, using the inputs presented to that edge.
  always @(posedge clk) begin
    bit  canIn, doPop, doAcc;
    op_t d;
    if (reset) begin
      modelQ.delete();
      pending = 1'b0;
      checkEn = 1'b1;
    end else if (flush) begin
      modelQ.delete();
      pending = 1'b0;
    end else begin
      canIn = (modelQ.size() < DEPTH);
      doPop = (modelQ.size() > 0) && out_ready;
      doAcc = in_valid && canIn;
      if (doPop) void'(modelQ.pop_front());
      if (doAcc) begin
        if (pending) begin
          d       = pendOp;
          d.imm   = in_word;
          pending = 1'b0;
          modelQ.push_back(d);
        end else begin
          d = modelDecode(in_word[11:0]);
          if (d.has_immediate) begin
            pendOp  = d;
            pending = 1'b1;
          end else begin
            modelQ.push_back(d);
          end
        end
      end
    end
  end

  // Per-cycle comparison of handshakes and head op against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ready", 64'(in_ready), 64'(modelQ.size() < DEPTH));
      checkOutput("out_valid", 64'(out_valid), 64'(modelQ.size() > 0));
      if (modelQ.size() > 0) begin
        checkOutput("head_op", 64'(dutOp), 64'(modelQ[0]));
      end
    end
  end

  // Presents one cycle of inputs and returns at the following falling edge.
  task automatic applyStimulus(input logic [11:0] w, input logic v, input logic ordy,
                               input logic fl, input logic rst);
    in_word   = w;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] w;
    int          r;
    in_word = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;

    // Reset state
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_fields", 64'(dutOp), 64'd0);

    // Simple arithmetic op, visible one cycle after acceptance
    applyStimulus(12'h0C0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("op0C0_valid", 64'(out_valid), 64'd1);
    checkOutput("op0C0_dest", 64'(dest_reg), 64'd0);
    checkOutput("op0C0_src", 64'(src_reg), 64'd0);
    checkOutput("op0C0_alu", 64'(alu_op), 64'h03);
    checkOutput("op0C0_rdest", 64'(read_dest), 64'd1);
    checkOutput("op0C0_himm", 64'(has_immediate), 64'd0);

    // Op with immediate
    applyStimulus(12'h007, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("imm_first_novalid", 64'(out_valid), 64'd0);
    applyStimulus(12'h5A5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("imm_valid", 64'(out_valid), 64'd1);
    checkOutput("imm_himm", 64'(has_immediate), 64'd1);
    checkOutput("imm_src", 64'(src_reg), 64'h07);
    checkOutput("imm_value", 64'(imm), 64'h5A5);

    // Load / store memory decode
    applyStimulus(12'h70A, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("ld_mem_read", 64'(mem_read), 64'd1);
    checkOutput("ld_base", 64'(mem_base), 64'd1);
    checkOutput("ld_postinc", 64'(mem_post_increment), 64'd1);
    checkOutput("ld_dest", 64'(dest_reg), 64'h00);
    applyStimulus(12'hF03, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("st_mem_write", 64'(mem_write), 64'd0);
    checkOutput("st_wdest", 64'(write_dest), 64'd1);
    checkOutput("st_dest", 64'(dest_reg), 64'h13);

    // Backpressure: queue fills, third word waits for a pop
    for (int k = 0; k < 3; k++) applyStimulus(12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(12'h0C0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(12'h0C8, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(12'h0D0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("full_hold_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_head_op1", 64'(dest_reg), 64'd0);
    applyStimulus(12'h0D0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("after_pop_head_op2", 64'(dest_reg), 64'd1);
    checkOutput("after_pop_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(12'h0D0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fifo_head_op3", 64'(dest_reg), 64'd2);
    applyStimulus(12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("drained", 64'(out_valid), 64'd0);

    // Flush drops the partial op and the offered word
    applyStimulus(12'h007, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(12'h5A5, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_no_out", 64'(out_valid), 64'd0);
    applyStimulus(12'h0C0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_valid", 64'(out_valid), 64'd1);
    checkOutput("post_flush_alu", 64'(alu_op), 64'h03);
    checkOutput("post_flush_imm", 64'(imm), 64'd0);

    // Reset while waiting for an immediate
    applyStimulus(12'h007, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(12'h0C8, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(12'h0C0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_opcode", 64'(alu_op), 64'h03);
    checkOutput("post_reset_himm", 64'(has_immediate), 64'd0);

    // Fill, then stream with simultaneous push and pop
    applyStimulus(12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(12'h0C0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(12'h0C8, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      w = 12'h0C0 | 12'(k << 3);
      applyStimulus(w, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("stream_valid", 64'(out_valid), 64'd1);
    end

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      w = 12'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 30) begin
        w[9] = 1'b0; w[2:0] = 3'b111;
      end else if (r < 55) begin
        w[11:8] = ($urandom_range(0, 1) == 1) ? 4'h7 : 4'hF;
      end else if (r < 65) begin
        w[10:7] = 4'hC;
      end else if (r < 70) begin
        w[10:3] = 8'hCD;
      end
      applyStimulus(w, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
